alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
Issue queue in front of the ALU in the out-of-order core.
- Accepts decoded ALU/branch/jump ops from the dispatcher.
- Holds each op until both source operands are available, capturing them from the ALU and LSB result broadcasts.
- Issues at most one ready op per cycle to the ALU, which is the block's sole consumer.
- Flushes on branch-mispredict clear.

Parameters:
RS_SIZE, 16, number of entries (power of 2)
RS_IDX_W, 4, log2(RS_SIZE)
OPENUM_W, 6, op-enum width
ROB_POS_W, 5, ROB position tag width (includes wrap bit)
DATA_W, 32, operand width
ADDR_W, 32, pc width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = freeze all state
clr  in  1  mispredict flush
disp_enable  in  1  dispatcher writes a new entry this cycle
disp_openum  in  OPENUM_W  operation
disp_rob_pos  in  ROB_POS_W  destination ROB tag
disp_rs1_ready  in  1  rs1 value valid
disp_rs1_val  in  DATA_W  rs1 value (valid when ready)
disp_rs1_tag  in  ROB_POS_W  producer tag (when not ready)
disp_rs2_ready / disp_rs2_val / disp_rs2_tag  in  1/DATA_W/ROB_POS_W  same for rs2
disp_imm  in  DATA_W  immediate
disp_pc  in  ADDR_W  instruction pc
rs_full  out  1  dispatcher must not assert disp_enable next cycle
alu_bc_enable / alu_bc_rob_pos / alu_bc_val  in  1/ROB_POS_W/DATA_W  ALU result broadcast
lsb_bc_enable / lsb_bc_rob_pos / lsb_bc_val  in  1/ROB_POS_W/DATA_W  load result broadcast
rs_to_alu_enable  out  1  issue valid (one-cycle pulse per op)
rs_to_alu_openum / rs_to_alu_rob_pos  out  OPENUM_W/ROB_POS_W  issued op and tag
rs_to_alu_rs1_val / rs_to_alu_rs2_val / rs_to_alu_imm  out  DATA_W  operands
rs_to_alu_pc  out  ADDR_W  pc

Behaviour:
- Per entry: busy, openum, rob_pos, q1_ready, v1, t1, q2_ready, v2, t2, imm, pc.
- Reset or clr:
  - all busy=0.
  - rs_to_alu_enable=0; all other outputs 0.
  - clr takes priority over a same-cycle dispatch; the dispatch is dropped.
- rdy low: no state change; outputs hold their values.
- Dispatch:
  - write the lowest-index non-busy entry at posedge.
  - For each source not ready: if alu_bc or lsb_bc is enabled in the same cycle with a matching tag, store the broadcast value and set ready (same-cycle forwarding).
  - ALU match wins over LSB match (both matching the same tag is illegal anyway).
- Wakeup: every posedge, for each busy entry and each non-ready source, a matching enabled broadcast sets ready=1 and latches the value.
- Ready condition: busy && q1_ready && q2_ready, evaluated on registered state only. An entry woken at edge N is issuable for output at edge N+1 at the earliest.
- Issue:
  - each cycle select the lowest-index ready entry.
  - At posedge, drive rs_to_alu_* registered from that entry, set enable=1, clear its busy.
  - If none ready, enable=0 and data outputs are don't-care (hold).
  - Latency: dispatch with both operands ready at edge N -> rs_to_alu_enable high after edge N+1.
- Dispatch and issue in the same cycle are legal. The freed entry is not reused until the next cycle.
- rs_full:
  - combinational; =1 when busy count >= RS_SIZE-1.
  - This one-entry margin covers the registered dispatcher handshake.
  - Dispatch into a completely full RS is illegal; assert in simulation.
- Tag comparisons use full ROB_POS_W, including the wrap bit.
- Branches/JAL/JALR/LUI/AUIPC flow through unchanged. The dispatcher marks an unused source as ready with value 0.

Decomposition:
- Shared definitions package holds the op-enum constants, the ROB tag, data and address widths, RS_SIZE, and the TRUE/FALSE constants.
- One sub-module: rs_prio_enc, a parameterised lowest-index priority encoder returning {found, idx}.
  - Instantiated twice: free-slot select and ready select.

Test Plan:
- Reset then dispatch ADD (rob 3, rs1=5, rs2=7, both ready) at edge 1 -> enable high after edge 2 with rob_pos=3, vals 5/7; rs_full=0.
- Dispatch SUB rob 4, rs1 waiting on tag 9; alu_bc tag 9 val 0x20 two cycles later -> issue one cycle after the broadcast, rs1_val=0x20.
- Dispatch with rs2 waiting on tag 6 while lsb_bc tag 6 val 0xDEAD is enabled in the same cycle -> issued next cycle with rs2_val=0xDEAD.
- Fill 15 entries all waiting on tag 1 -> rs_full=1 at count 15. Broadcast tag 1 -> issues in index order 0..14 on consecutive cycles; rs_full drops after the first issue.
- With 4 entries busy, assert clr together with disp_enable -> next cycle all busy=0, rs_to_alu_enable=0, no stale issue afterwards.
- rdy low for 3 cycles with a ready entry, then high -> no issue while low; issue on the first cycle after rdy rises; broadcasts during rdy-low are ignored.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station slice.
// Holds the default geometry, the ROB tag, data and address widths,
// the op-enum encoding shared with the dispatcher and ALU, and the
// TRUE/FALSE constants used for flag writes.
package alu_reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = 4;
    localparam int OPENUM_W  = 6;
    localparam int ROB_POS_W = 5;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [ROB_POS_W-1:0] rob_pos_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    typedef enum logic [OPENUM_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } openum_e;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder.
// Ports:
//   req_i   : request vector, bit 0 has highest priority
//   found_o : at least one request bit set
//   idx_o   : index of the lowest set bit (0 when none set)
module rs_prio_enc
    import alu_reservation_station_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found = FALSE;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                found = TRUE;
                idx   = IDX_W'(i);
            end
        end
    end

    assign found_o = found;
    assign idx_o   = idx;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: issue queue in front of the ALU.
// Holds dispatched ALU/branch/jump ops until both sources are available,
// snooping the ALU and LSB result broadcasts, and issues the lowest-index
// ready entry each cycle as a registered one-cycle pulse.
// Ports:
//   clk, rst (sync, active-high), rdy (low freezes state), clr (flush)
//   disp_*      : new entry from the dispatcher
//   rs_full     : dispatcher must stop (one-entry margin)
//   alu_bc_*    : ALU result broadcast
//   lsb_bc_*    : load result broadcast
//   rs_to_alu_* : registered issue to the ALU
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE   = alu_reservation_station_pkg::RS_SIZE,
    parameter int RS_IDX_W  = alu_reservation_station_pkg::RS_IDX_W,
    parameter int OPENUM_W  = alu_reservation_station_pkg::OPENUM_W,
    parameter int ROB_POS_W = alu_reservation_station_pkg::ROB_POS_W,
    parameter int DATA_W    = alu_reservation_station_pkg::DATA_W,
    parameter int ADDR_W    = alu_reservation_station_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,

    input  logic                 disp_enable,
    input  logic [OPENUM_W-1:0]  disp_openum,
    input  logic [ROB_POS_W-1:0] disp_rob_pos,
    input  logic                 disp_rs1_ready,
    input  logic [DATA_W-1:0]    disp_rs1_val,
    input  logic [ROB_POS_W-1:0] disp_rs1_tag,
    input  logic                 disp_rs2_ready,
    input  logic [DATA_W-1:0]    disp_rs2_val,
    input  logic [ROB_POS_W-1:0] disp_rs2_tag,
    input  logic [DATA_W-1:0]    disp_imm,
    input  logic [ADDR_W-1:0]    disp_pc,
    output logic                 rs_full,

    input  logic                 alu_bc_enable,
    input  logic [ROB_POS_W-1:0] alu_bc_rob_pos,
    input  logic [DATA_W-1:0]    alu_bc_val,
    input  logic                 lsb_bc_enable,
    input  logic [ROB_POS_W-1:0] lsb_bc_rob_pos,
    input  logic [DATA_W-1:0]    lsb_bc_val,

    output logic                 rs_to_alu_enable,
    output logic [OPENUM_W-1:0]  rs_to_alu_openum,
    output logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
    output logic [DATA_W-1:0]    rs_to_alu_rs1_val,
    output logic [DATA_W-1:0]    rs_to_alu_rs2_val,
    output logic [DATA_W-1:0]    rs_to_alu_imm,
    output logic [ADDR_W-1:0]    rs_to_alu_pc
);

    localparam int CNT_W = RS_IDX_W + 1;

    // Entry storage
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   q1_q,   q1_d;
    logic [RS_SIZE-1:0]   q2_q,   q2_d;
    logic [OPENUM_W-1:0]  op_q  [RS_SIZE], op_d  [RS_SIZE];
    logic [ROB_POS_W-1:0] rob_q [RS_SIZE], rob_d [RS_SIZE];
    logic [ROB_POS_W-1:0] t1_q  [RS_SIZE], t1_d  [RS_SIZE];
    logic [ROB_POS_W-1:0] t2_q  [RS_SIZE], t2_d  [RS_SIZE];
    logic [DATA_W-1:0]    v1_q  [RS_SIZE], v1_d  [RS_SIZE];
    logic [DATA_W-1:0]    v2_q  [RS_SIZE], v2_d  [RS_SIZE];
    logic [DATA_W-1:0]    imm_q [RS_SIZE], imm_d [RS_SIZE];
    logic [ADDR_W-1:0]    pc_q  [RS_SIZE], pc_d  [RS_SIZE];

    // Issue registers
    logic                 iss_en_q,  iss_en_d;
    logic [OPENUM_W-1:0]  iss_op_q,  iss_op_d;
    logic [ROB_POS_W-1:0] iss_rob_q, iss_rob_d;
    logic [DATA_W-1:0]    iss_v1_q,  iss_v1_d;
    logic [DATA_W-1:0]    iss_v2_q,  iss_v2_d;
    logic [DATA_W-1:0]    iss_imm_q, iss_imm_d;
    logic [ADDR_W-1:0]    iss_pc_q,  iss_pc_d;

    logic                 free_found, ready_found;
    logic [RS_IDX_W-1:0]  free_idx,   ready_idx;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [CNT_W-1:0]     busy_cnt;

    // Readiness is taken from registered flags only, so a broadcast that
    // wakes an entry at edge N makes it issuable at edge N+1.
    assign ready_vec = busy_q & q1_q & q2_q;

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
        .req_i   (ready_vec),
        .found_o (ready_found),
        .idx_o   (ready_idx)
    );

    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
        end
    end

    // One-entry margin: the dispatcher sees rs_full a cycle late.
    assign rs_full = (busy_cnt >= CNT_W'(RS_SIZE - 1));

    // Entry next-state: wakeup, issue-clear, dispatch write, flush.
    always_comb begin
        busy_d = busy_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        op_d   = op_q;
        rob_d  = rob_q;
        t1_d   = t1_q;
        t2_d   = t2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;

        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && !q1_q[i]) begin
                if (alu_bc_enable && alu_bc_rob_pos == t1_q[i]) begin
                    q1_d[i] = TRUE;
                    v1_d[i] = alu_bc_val;
                end else if (lsb_bc_enable && lsb_bc_rob_pos == t1_q[i]) begin
                    q1_d[i] = TRUE;
                    v1_d[i] = lsb_bc_val;
                end
            end
            if (busy_q[i] && !q2_q[i]) begin
                if (alu_bc_enable && alu_bc_rob_pos == t2_q[i]) begin
                    q2_d[i] = TRUE;
                    v2_d[i] = alu_bc_val;
                end else if (lsb_bc_enable && lsb_bc_rob_pos == t2_q[i]) begin
                    q2_d[i] = TRUE;
                    v2_d[i] = lsb_bc_val;
                end
            end
        end

        if (ready_found) begin
            busy_d[ready_idx] = FALSE;
        end

        // The free slot comes from registered busy, so a slot being issued
        // this cycle is never chosen for the same-cycle dispatch.
        if (disp_enable && free_found) begin
            busy_d[free_idx] = TRUE;
            op_d[free_idx]   = disp_openum;
            rob_d[free_idx]  = disp_rob_pos;
            imm_d[free_idx]  = disp_imm;
            pc_d[free_idx]   = disp_pc;
            t1_d[free_idx]   = disp_rs1_tag;
            t2_d[free_idx]   = disp_rs2_tag;
            q1_d[free_idx]   = disp_rs1_ready;
            v1_d[free_idx]   = disp_rs1_val;
            q2_d[free_idx]   = disp_rs2_ready;
            v2_d[free_idx]   = disp_rs2_val;
            if (!disp_rs1_ready) begin
                if (alu_bc_enable && alu_bc_rob_pos == disp_rs1_tag) begin
                    q1_d[free_idx] = TRUE;
                    v1_d[free_idx] = alu_bc_val;
                end else if (lsb_bc_enable && lsb_bc_rob_pos == disp_rs1_tag) begin
                    q1_d[free_idx] = TRUE;
                    v1_d[free_idx] = lsb_bc_val;
                end
            end
            if (!disp_rs2_ready) begin
                if (alu_bc_enable && alu_bc_rob_pos == disp_rs2_tag) begin
                    q2_d[free_idx] = TRUE;
                    v2_d[free_idx] = alu_bc_val;
                end else if (lsb_bc_enable && lsb_bc_rob_pos == disp_rs2_tag) begin
                    q2_d[free_idx] = TRUE;
                    v2_d[free_idx] = lsb_bc_val;
                end
            end
        end

        if (clr) begin
            busy_d = '0;
        end
    end

    // Issue next-state: data holds when nothing is ready.
    always_comb begin
        iss_en_d  = ready_found;
        iss_op_d  = iss_op_q;
        iss_rob_d = iss_rob_q;
        iss_v1_d  = iss_v1_q;
        iss_v2_d  = iss_v2_q;
        iss_imm_d = iss_imm_q;
        iss_pc_d  = iss_pc_q;
        if (ready_found) begin
            iss_op_d  = op_q[ready_idx];
            iss_rob_d = rob_q[ready_idx];
            iss_v1_d  = v1_q[ready_idx];
            iss_v2_d  = v2_q[ready_idx];
            iss_imm_d = imm_q[ready_idx];
            iss_pc_d  = pc_q[ready_idx];
        end
        if (clr) begin
            iss_en_d  = FALSE;
            iss_op_d  = '0;
            iss_rob_d = '0;
            iss_v1_d  = '0;
            iss_v2_d  = '0;
            iss_imm_d = '0;
            iss_pc_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            q1_q      <= '0;
            q2_q      <= '0;
            iss_en_q  <= FALSE;
            iss_op_q  <= '0;
            iss_rob_q <= '0;
            iss_v1_q  <= '0;
            iss_v2_q  <= '0;
            iss_imm_q <= '0;
            iss_pc_q  <= '0;
        end else if (rdy) begin
            busy_q    <= busy_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            iss_en_q  <= iss_en_d;
            iss_op_q  <= iss_op_d;
            iss_rob_q <= iss_rob_d;
            iss_v1_q  <= iss_v1_d;
            iss_v2_q  <= iss_v2_d;
            iss_imm_q <= iss_imm_d;
            iss_pc_q  <= iss_pc_d;
        end
    end

    // Payload fields only matter while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            op_q  <= op_d;
            rob_q <= rob_d;
            t1_q  <= t1_d;
            t2_q  <= t2_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && !clr && disp_enable) begin
            assert (free_found)
                else $error("dispatch into a completely full reservation station");
        end
    end

    assign rs_to_alu_enable  = iss_en_q;
    assign rs_to_alu_openum  = iss_op_q;
    assign rs_to_alu_rob_pos = iss_rob_q;
    assign rs_to_alu_rs1_val = iss_v1_q;
    assign rs_to_alu_rs2_val = iss_v2_q;
    assign rs_to_alu_imm     = iss_imm_q;
    assign rs_to_alu_pc      = iss_pc_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: scenario tasks with a queue of
// expected issues, popped and compared whenever the DUT issues.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, rdy, clr;
    logic                 disp_enable;
    logic [OPENUM_W-1:0]  disp_openum;
    logic [ROB_POS_W-1:0] disp_rob_pos, disp_rs1_tag, disp_rs2_tag;
    logic                 disp_rs1_ready, disp_rs2_ready;
    logic [DATA_W-1:0]    disp_rs1_val, disp_rs2_val, disp_imm;
    logic [ADDR_W-1:0]    disp_pc;
    logic                 rs_full;
    logic                 alu_bc_enable, lsb_bc_enable;
    logic [ROB_POS_W-1:0] alu_bc_rob_pos, lsb_bc_rob_pos;
    logic [DATA_W-1:0]    alu_bc_val, lsb_bc_val;
    logic                 rs_to_alu_enable;
    logic [OPENUM_W-1:0]  rs_to_alu_openum;
    logic [ROB_POS_W-1:0] rs_to_alu_rob_pos;
    logic [DATA_W-1:0]    rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm;
    logic [ADDR_W-1:0]    rs_to_alu_pc;

    typedef struct packed {
        logic [OPENUM_W-1:0]  op;
        logic [ROB_POS_W-1:0] rob;
        logic [DATA_W-1:0]    v1;
        logic [DATA_W-1:0]    v2;
        logic [DATA_W-1:0]    imm;
        logic [ADDR_W-1:0]    pc;
    } iss_t;

    iss_t exp_q[$];
    iss_t got;
    int   checks = 0;
    int   passes = 0;

    assign got = {rs_to_alu_openum, rs_to_alu_rob_pos, rs_to_alu_rs1_val,
                  rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc};

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .clr               (clr),
        .disp_enable       (disp_enable),
        .disp_openum       (disp_openum),
        .disp_rob_pos      (disp_rob_pos),
        .disp_rs1_ready    (disp_rs1_ready),
        .disp_rs1_val      (disp_rs1_val),
        .disp_rs1_tag      (disp_rs1_tag),
        .disp_rs2_ready    (disp_rs2_ready),
        .disp_rs2_val      (disp_rs2_val),
        .disp_rs2_tag      (disp_rs2_tag),
        .disp_imm          (disp_imm),
        .disp_pc           (disp_pc),
        .rs_full           (rs_full),
        .alu_bc_enable     (alu_bc_enable),
        .alu_bc_rob_pos    (alu_bc_rob_pos),
        .alu_bc_val        (alu_bc_val),
        .lsb_bc_enable     (lsb_bc_enable),
        .lsb_bc_rob_pos    (lsb_bc_rob_pos),
        .lsb_bc_val        (lsb_bc_val),
        .rs_to_alu_enable  (rs_to_alu_enable),
        .rs_to_alu_openum  (rs_to_alu_openum),
        .rs_to_alu_rob_pos (rs_to_alu_rob_pos),
        .rs_to_alu_rs1_val (rs_to_alu_rs1_val),
        .rs_to_alu_rs2_val (rs_to_alu_rs2_val),
        .rs_to_alu_imm     (rs_to_alu_imm),
        .rs_to_alu_pc      (rs_to_alu_pc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [OPENUM_W-1:0] op, input logic [ROB_POS_W-1:0] rob,
                              input logic r1, input logic [DATA_W-1:0] v1, input logic [ROB_POS_W-1:0] t1,
                              input logic r2, input logic [DATA_W-1:0] v2, input logic [ROB_POS_W-1:0] t2,
                              input logic [DATA_W-1:0] imm, input logic [ADDR_W-1:0] pc);
        disp_enable    = 1'b1;
        disp_openum    = op;
        disp_rob_pos   = rob;
        disp_rs1_ready = r1;
        disp_rs1_val   = v1;
        disp_rs1_tag   = t1;
        disp_rs2_ready = r2;
        disp_rs2_val   = v2;
        disp_rs2_tag   = t2;
        disp_imm       = imm;
        disp_pc        = pc;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        disp_enable = 1'b0; disp_openum = '0; disp_rob_pos = '0;
        disp_rs1_ready = 1'b0; disp_rs1_val = '0; disp_rs1_tag = '0;
        disp_rs2_ready = 1'b0; disp_rs2_val = '0; disp_rs2_tag = '0;
        disp_imm = '0; disp_pc = '0;
        alu_bc_enable = 1'b0; alu_bc_rob_pos = '0; alu_bc_val = '0;
        lsb_bc_enable = 1'b0; lsb_bc_rob_pos = '0; lsb_bc_val = '0;
        tick;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", rs_to_alu_enable);
        else passes++;
        checks++;
        if (got !== '0) $display("FAIL reset_outputs: got %h want 0", got);
        else passes++;
        checks++;
        if (rs_full !== 1'b0) $display("FAIL reset_full: got %b want 0", rs_full);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_add;
        iss_t e;
        drive_disp(OP_ADD, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 32'h11, 32'h1000);
        exp_q.push_back({OP_ADD, 5'd3, 32'd5, 32'd7, 32'h11, 32'h1000});
        tick;
        disp_enable = 1'b0;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL add_early: got %b want 0", rs_to_alu_enable);
        else passes++;
        checks++;
        if (rs_full !== 1'b0) $display("FAIL add_full: got %b want 0", rs_full);
        else passes++;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL add_issue: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL add_issue: got %h want %h", got, e);
            else passes++;
        end
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL add_pulse: got %b want 0", rs_to_alu_enable);
        else passes++;
    endtask

    task automatic test_wakeup;
        iss_t e;
        drive_disp(OP_SUB, 5'd4, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0, 32'd0, 32'h1004);
        exp_q.push_back({OP_SUB, 5'd4, 32'h20, 32'd3, 32'd0, 32'h1004});
        tick;
        disp_enable = 1'b0;
        // Same low bits, different wrap bit: must not wake.
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd25; alu_bc_val = 32'hBAD;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL wake_wrapbit: got %b want 0", rs_to_alu_enable);
        else passes++;
        alu_bc_rob_pos = 5'd9; alu_bc_val = 32'h20;
        tick;
        alu_bc_enable = 1'b0;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL wake_early: got %b want 0", rs_to_alu_enable);
        else passes++;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL wake_issue: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL wake_issue: got %h want %h", got, e);
            else passes++;
        end
    endtask

    task automatic test_forward;
        iss_t e;
        drive_disp(OP_XOR, 5'd5, 1'b0, 32'd0, 5'd7, 1'b0, 32'd0, 5'd6, 32'h5, 32'h1008);
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd7; alu_bc_val = 32'h77;
        lsb_bc_enable = 1'b1; lsb_bc_rob_pos = 5'd6; lsb_bc_val = 32'hDEAD;
        exp_q.push_back({OP_XOR, 5'd5, 32'h77, 32'hDEAD, 32'h5, 32'h1008});
        tick;
        disp_enable = 1'b0; alu_bc_enable = 1'b0; lsb_bc_enable = 1'b0;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL fwd_early: got %b want 0", rs_to_alu_enable);
        else passes++;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL fwd_issue: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL fwd_issue: got %h want %h", got, e);
            else passes++;
        end
        tick;
    endtask

    task automatic test_back_to_back;
        iss_t e;
        for (int k = 0; k < 3; k++) begin
            drive_disp(OP_ADD, 5'(10 + k), 1'b1, 32'(2 * k + 1), 5'd0, 1'b1, 32'(2 * k + 2), 5'd0,
                       32'(k), 32'(32'h2000 + 4 * k));
            exp_q.push_back({OP_ADD, 5'(10 + k), 32'(2 * k + 1), 32'(2 * k + 2), 32'(k), 32'(32'h2000 + 4 * k)});
            tick;
            if (k > 0) begin
                checks++;
                if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
                    $display("FAIL b2b_issue%0d: enable %b want 1", k - 1, rs_to_alu_enable);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) $display("FAIL b2b_issue%0d: got %h want %h", k - 1, got, e);
                    else passes++;
                end
            end
        end
        disp_enable = 1'b0;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL b2b_issue2: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL b2b_issue2: got %h want %h", got, e);
            else passes++;
        end
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL b2b_idle: got %b want 0", rs_to_alu_enable);
        else passes++;
    endtask

    task automatic test_full;
        iss_t e;
        for (int k = 0; k < 15; k++) begin
            drive_disp(OP_OR, 5'(k), 1'b0, 32'd0, 5'd1, 1'b1, 32'(k), 5'd0, 32'd0, 32'(32'h3000 + 4 * k));
            exp_q.push_back({OP_OR, 5'(k), 32'h100, 32'(k), 32'd0, 32'(32'h3000 + 4 * k)});
            tick;
            checks++;
            if (rs_full !== logic'(k + 1 >= 15)) $display("FAIL full_cnt%0d: got %b want %b", k + 1, rs_full, (k + 1 >= 15));
            else passes++;
        end
        disp_enable = 1'b0;
        lsb_bc_enable = 1'b1; lsb_bc_rob_pos = 5'd1; lsb_bc_val = 32'h100;
        tick;
        lsb_bc_enable = 1'b0;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL full_wake_early: got %b want 0", rs_to_alu_enable);
        else passes++;
        for (int k = 0; k < 15; k++) begin
            tick;
            checks++;
            if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
                $display("FAIL full_issue%0d: enable %b want 1", k, rs_to_alu_enable);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL full_issue%0d: got %h want %h", k, got, e);
                else passes++;
            end
            if (k == 0) begin
                checks++;
                if (rs_full !== 1'b0) $display("FAIL full_drop: got %b want 0", rs_full);
                else passes++;
            end
        end
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL full_drained: got %b want 0", rs_to_alu_enable);
        else passes++;
    endtask

    task automatic test_clr;
        int seen;
        for (int k = 0; k < 4; k++) begin
            drive_disp(OP_AND, 5'(16 + k), 1'b0, 32'd0, 5'd2, 1'b1, 32'd1, 5'd0, 32'd0, 32'h4000);
            tick;
        end
        drive_disp(OP_ADD, 5'd22, 1'b1, 32'd8, 5'd0, 1'b1, 32'd9, 5'd0, 32'd0, 32'h4100);
        clr = 1'b1;
        tick;
        clr = 1'b0; disp_enable = 1'b0;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL clr_enable: got %b want 0", rs_to_alu_enable);
        else passes++;
        checks++;
        if (got !== '0) $display("FAIL clr_outputs: got %h want 0", got);
        else passes++;
        checks++;
        if (rs_full !== 1'b0) $display("FAIL clr_full: got %b want 0", rs_full);
        else passes++;
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd2; alu_bc_val = 32'h1;
        tick;
        alu_bc_enable = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (rs_to_alu_enable) seen++;
            tick;
        end
        checks++;
        if (seen !== 0) $display("FAIL clr_stale: got %0d issues want 0", seen);
        else passes++;
    endtask

    task automatic test_rdy;
        iss_t e;
        iss_t a_exp;
        drive_disp(OP_SLT, 5'd21, 1'b0, 32'd0, 5'd12, 1'b1, 32'd9, 5'd0, 32'd0, 32'h5000);
        tick;
        drive_disp(OP_SLTU, 5'd20, 1'b1, 32'hA, 5'd0, 1'b1, 32'hB, 5'd0, 32'h3, 32'h5004);
        a_exp = {OP_SLTU, 5'd20, 32'hA, 32'hB, 32'h3, 32'h5004};
        exp_q.push_back(a_exp);
        tick;
        disp_enable = 1'b0;
        rdy = 1'b0;
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd12; alu_bc_val = 32'h55;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (rs_to_alu_enable !== 1'b0) $display("FAIL rdy_frozen%0d: got %b want 0", k, rs_to_alu_enable);
            else passes++;
        end
        rdy = 1'b1; alu_bc_enable = 1'b0;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL rdy_issue: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL rdy_issue: got %h want %h", got, e);
            else passes++;
        end
        rdy = 1'b0;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || got !== a_exp)
            $display("FAIL rdy_hold: got %b/%h want 1/%h", rs_to_alu_enable, got, a_exp);
        else passes++;
        rdy = 1'b1;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b0) $display("FAIL rdy_bc_ignored: got %b want 0", rs_to_alu_enable);
        else passes++;
        alu_bc_enable = 1'b1; alu_bc_rob_pos = 5'd12; alu_bc_val = 32'h66;
        exp_q.push_back({OP_SLT, 5'd21, 32'h66, 32'd9, 32'd0, 32'h5000});
        tick;
        alu_bc_enable = 1'b0;
        tick;
        checks++;
        if (rs_to_alu_enable !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL rdy_late_issue: enable %b want 1", rs_to_alu_enable);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL rdy_late_issue: got %h want %h", got, e);
            else passes++;
        end
        tick;
        checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_wakeup;
        test_forward;
        test_back_to_back;
        test_full;
        test_clr;
        test_rdy;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
